video_timing: RTL
=================

# video_timing

Parametrised raster timing and pixel-address generator for the 240p test suite: a pixel-clock enable divider, horizontal/vertical counters, blank/sync/DE, and a linear framebuffer address for pattern ROMs. Selects between a 60 Hz (240-line) and a 50 Hz (288-line) mode at frame boundaries, with optional 480i/576i field alternation. Sits between the clock domain and the pattern/layer compositor, replacing per-pattern hard-coded timing.

## Interface
- CLK_DIV, 4: clk cycles per pixel, ≥2
- H_ACTIVE, 320; H_FP, 8; H_SYNC, 32; H_BP, 32: horizontal pixels; H_TOTAL = sum
- V_ACTIVE_60, 240; V_TOTAL_60, 262: 60 Hz mode lines
- V_ACTIVE_50, 288; V_TOTAL_50, 312: 50 Hz mode lines
- V_FP, 3; V_SYNC, 3: vertical porch/sync lines, both modes
- HSYNC_POL, 0; VSYNC_POL, 1: active level of sync outputs
- AW, 17: address width
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mode_pal  in  1  requested mode (1 = 50 Hz), sampled at frame wrap
- interlace  in  1  requested interlace, sampled at frame wrap (ignored without INTERLACE_EN)
- ce_pix  out  1  pixel enable, one clk every CLK_DIV
- hc  out  10  horizontal counter 0..H_TOTAL-1
- vc  out  10  vertical counter 0..V_TOTAL-1 (or V_TOTAL in field 1)
- h_blank, v_blank, de  out  1 each
- h_sync, v_sync  out  1 each, polarity per parameter
- frame_start  out  1  one-clk pulse on entry to (0,0)
- field  out  1  current field
- mode_active  out  1  latched mode
- addr  out  AW  linear pixel address

## Operation
- Divider: div counts 0..CLK_DIV-1; ce_pix registered high for the clk after div == CLK_DIV-1.
- Counters advance only on ce_pix: hc wraps at H_TOTAL-1 → 0 and increments vc; vc wraps at last line → 0.
- Reset: hc = H_TOTAL-1, vc = V_TOTAL_60-1, div = 0, ce_pix = 0, h_blank = v_blank = 1, de = 0, syncs inactive, frame_start = 0, field = 0, mode_active = 0, addr = 0. First ce_pix wraps to (0,0) and performs a normal frame start.
- Frame wrap (→(0,0)): latch mode_pal into mode_active and interlace into the interlace state; addr = 0; frame_start = 1 for that clk.
- Decode (registered, consistent with hc/vc in the same clk): h_blank = hc ≥ H_ACTIVE; h_sync active for hc ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); v_blank = vc ≥ V_ACTIVE; v_sync active for vc ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), switching when hc = 0; de = !h_blank && !v_blank.
- addr: incremented on each ce_pix that leaves a de = 1 pixel, so addr = vc·H_ACTIVE+hc whenever de = 1; held during blanking; wraps modulo 2^AW.
- mode_pal/interlace changes mid-frame have no effect until the next wrap.

## Timing
- hc/vc and all decoded outputs update on the clk where ce_pix = 1 and remain stable for CLK_DIV clks.
- Line = H_TOTAL·CLK_DIV clks; progressive frame = V_TOTAL lines.
- Downstream ROM reads addr with 1-clk latency; pixel is valid well before the next ce_pix.
- Reset deassertion: first ce_pix at clk CLK_DIV after release.
- Counter width rule: H_TOTAL ≤ 1024, V_TOTAL_50+1 ≤ 1024.

## Configuration
- INTERLACE_EN defined: when the latched interlace = 1, field toggles at each wrap; field 1 has V_TOTAL+1 lines; in field 1, v_sync edges occur at hc = H_TOTAL/2 instead of hc = 0; addr restarts per field.
- Undefined: interlace input ignored, field tied 0, every frame V_TOTAL lines.

## Structure
- Package video_pkg: mode enum (MODE_60, MODE_50), per-mode vertical timing struct, counter width localparam, H_TOTAL derivation.
- Sub-module ce_divider (parameter CLK_DIV, outputs ce_pix).

## Test plan
- Defaults, mode_pal = 0 → ce_pix period 4 clks; frame_start period 392·262·4 = 410816 clks; 76800 de pixels/frame; last active addr = 76799.
- mode_pal 0→1 mid-frame → current frame stays 262 lines; next frame 312 lines, mode_active = 1, 92160 de pixels.
- hc = 328 → h_sync goes active (0); hc = 360 → h_sync returns 1; v_sync high for vc 243..245 in 60 Hz mode.
- reset_n low for 3 clks mid-line, then released → outputs at reset values immediately (async); first ce_pix wraps to (0,0) with frame_start pulse and addr = 0.
- INTERLACE_EN, interlace = 1 → field alternates 0/1; field lengths 262/263 lines; field 1 v_sync asserts at vc = 243, hc = 196.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the 240p raster generator: counter width,
// refresh-mode encoding and the per-mode vertical timing bundle.
package video_pkg;

  localparam int CW = 10;

  typedef enum logic {
    MODE_60 = 1'b0,
    MODE_50 = 1'b1
  } mode_e;

  typedef struct packed {
    logic [CW-1:0] v_active;
    logic [CW-1:0] v_total;
  } vtiming_t;

  function automatic int h_total_f(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic vtiming_t vt_f(
    input int act,
    input int tot
  );
    vtiming_t t;
    t.v_active = CW'(act);
    t.v_total  = CW'(tot);
    return t;
  endfunction

endpackage

// File: rtl/video_timing_ce_divider.sv
// Pixel-clock enable: ce_next flags the last divider phase,
// ce_pix is its registered copy (one clk in every CLK_DIV).
module ce_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic ce_next,
  output logic ce_pix
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          ce_pix_q;
  logic          ce_pix_d;

  always_comb begin
    ce_next  = (div_q == DIV_MAX);
    div_d    = ce_next ? '0 : div_q + DW'(1);
    ce_pix_d = ce_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      ce_pix_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      ce_pix_q <= ce_pix_d;
    end
  end

  assign ce_pix = ce_pix_q;

endmodule

// File: rtl/video_timing.sv
// Raster timing / pixel-address generator, 60/50 Hz selectable.
// Define INTERLACE_EN for 480i/576i field alternation.
module video_timing
  import video_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 320,
  parameter int H_FP        = 8,
  parameter int H_SYNC      = 32,
  parameter int H_BP        = 32,
  parameter int V_ACTIVE_60 = 240,
  parameter int V_TOTAL_60  = 262,
  parameter int V_ACTIVE_50 = 288,
  parameter int V_TOTAL_50  = 312,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 3,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b1,
  parameter int AW          = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mode_pal,
  input  logic          interlace,
  output logic          ce_pix,
  output logic [9:0]    hc,
  output logic [9:0]    vc,
  output logic          h_blank,
  output logic          v_blank,
  output logic          de,
  output logic          h_sync,
  output logic          v_sync,
  output logic          frame_start,
  output logic          field,
  output logic          mode_active,
  output logic [AW-1:0] addr
);

  localparam int H_TOTAL = h_total_f(H_ACTIVE, H_FP, H_SYNC, H_BP);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_HALF = CW'(H_TOTAL / 2);
  localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_ON  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VFP    = CW'(V_FP);
  localparam logic [CW-1:0] VSW    = CW'(V_SYNC);
  localparam logic [CW-1:0] V_RST  = CW'(V_TOTAL_60 - 1);

  localparam vtiming_t VT_60 = vt_f(V_ACTIVE_60, V_TOTAL_60);
  localparam vtiming_t VT_50 = vt_f(V_ACTIVE_50, V_TOTAL_50);

  logic ce_next;

  ce_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_ce (
    .clk     (clk),
    .reset_n (reset_n),
    .ce_next (ce_next),
    .ce_pix  (ce_pix)
  );

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  mode_e         mode_q, mode_d;
  logic          field_q, field_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          frame_start_q, frame_start_d;
  logic          h_blank_q, h_blank_d;
  logic          v_blank_q, v_blank_d;
  logic          de_q, de_d;
  logic          hs_act_q, hs_act_d;
  logic          vs_act_q, vs_act_d;

  vtiming_t      vt_cur;
  vtiming_t      vt_nxt;
  logic [CW-1:0] v_last;
  logic [CW-1:0] vs_on;
  logic [CW-1:0] vs_off;
  logic          wrap;

  // Raster advance; mode and field are only re-latched at the frame wrap.
  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    mode_d        = mode_q;
    field_d       = field_q;
    addr_d        = addr_q;
    frame_start_d = 1'b0;
    wrap          = 1'b0;
    vt_cur        = (mode_q == MODE_50) ? VT_50 : VT_60;
    v_last        = vt_cur.v_total - CW'(1) + CW'(field_q);
    if (ce_next) begin
      if (de_q) begin
        addr_d = addr_q + AW'(1);
      end
      if (hc_q != H_LAST) begin
        hc_d = hc_q + CW'(1);
      end else begin
        hc_d = '0;
        if (vc_q != v_last) begin
          vc_d = vc_q + CW'(1);
        end else begin
          vc_d = '0;
          wrap = 1'b1;
        end
      end
    end
    if (wrap) begin
      mode_d        = mode_e'(mode_pal);
      addr_d        = '0;
      frame_start_d = 1'b1;
`ifdef INTERLACE_EN
      field_d       = interlace & ~field_q;
`endif
    end
  end

`ifndef INTERLACE_EN
  logic unused_interlace;
  assign unused_interlace = interlace;
`endif

  // Decode from the next position so flags line up with hc/vc.
  always_comb begin
    vt_nxt    = (mode_d == MODE_50) ? VT_50 : VT_60;
    vs_on     = vt_nxt.v_active + VFP;
    vs_off    = vs_on + VSW;
    h_blank_d = (hc_d >= HA);
    hs_act_d  = (hc_d >= HS_ON) && (hc_d < HS_OFF);
    v_blank_d = (vc_d >= vt_nxt.v_active);
    vs_act_d  = (vc_d >= vs_on) && (vc_d < vs_off);
    if (field_d) begin
      vs_act_d = ({vc_d, hc_d} >= {vs_on, H_HALF}) &&
                 ({vc_d, hc_d} <  {vs_off, H_HALF});
    end
    de_d = !h_blank_d && !v_blank_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= H_LAST;
      vc_q          <= V_RST;
      mode_q        <= MODE_60;
      field_q       <= 1'b0;
      addr_q        <= '0;
      frame_start_q <= 1'b0;
      h_blank_q     <= 1'b1;
      v_blank_q     <= 1'b1;
      de_q          <= 1'b0;
      hs_act_q      <= 1'b0;
      vs_act_q      <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mode_q        <= mode_d;
      field_q       <= field_d;
      addr_q        <= addr_d;
      frame_start_q <= frame_start_d;
      h_blank_q     <= h_blank_d;
      v_blank_q     <= v_blank_d;
      de_q          <= de_d;
      hs_act_q      <= hs_act_d;
      vs_act_q      <= vs_act_d;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign h_blank     = h_blank_q;
  assign v_blank     = v_blank_q;
  assign de          = de_q;
  assign h_sync      = hs_act_q ? HSYNC_POL : ~HSYNC_POL;
  assign v_sync      = vs_act_q ? VSYNC_POL : ~VSYNC_POL;
  assign frame_start = frame_start_q;
  assign field       = field_q;
  assign mode_active = (mode_q == MODE_50);
  assign addr        = addr_q;

endmodule
